// File: rtl/ieee754_top.sv
// Board top: keys a 16-bit signed integer in hex nibbles and shows its IEEE-754 single-precision pattern on 8 seven-segment digits.
// Optional button debouncing is enabled by defining DEBOUNCE_EN.
module ieee754_top #(
  parameter int unsigned REFRESH_DIV     = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk100mhz,
  input  logic       reset,
  input  logic [3:0] switches,
  input  logic       enter,
  input  logic       confirm,
  output logic [7:0] anodes,
  output logic [7:0] cathodes
);

  typedef enum logic {ENTRY, SHOW} state_t;

  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

  state_t      state, state_n;
  logic [15:0] value, value_n;
  logic [2:0]  count, count_n;
  logic [31:0] result, result_n;
  logic [31:0] conv;

  // bit0 = enter, bit1 = confirm
  logic [1:0] btn_s1, btn_s2, btn_level, btn_prev, btn_pulse;

  always_ff @(posedge clk100mhz or negedge reset) begin
    if (!reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      btn_s1 <= {confirm, enter};
      btn_s2 <= btn_s1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  logic [DBW-1:0] db_cnt [2];

  // A new level is accepted only after it has been stable for DEBOUNCE_CYCLES clocks
  always_ff @(posedge clk100mhz or negedge reset) begin
    if (!reset) begin
      btn_level <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (btn_s2[i] != btn_level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            btn_level[i] <= btn_s2[i];
            db_cnt[i]    <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign btn_level = btn_s2;
`endif

  always_ff @(posedge clk100mhz or negedge reset) begin
    if (!reset) btn_prev <= '0;
    else        btn_prev <= btn_level;
  end

  assign btn_pulse = btn_level & ~btn_prev;

  // Integer to float: exact, since a 17-bit magnitude always fits in 24 significand bits
  logic [16:0] vext, mag;
  logic [4:0]  lead;
  always_comb begin
    vext = {value[15], value};
    mag  = value[15] ? (~vext + 17'd1) : vext;
    lead = '0;
    for (int unsigned i = 0; i < 17; i++) begin
      if (mag[i]) lead = 5'(i);
    end
    if (value == 16'h0000) conv = '0;
    else conv = {value[15], 8'd127 + {3'b000, lead}, 23'({mag, 23'b0} >> lead)};
  end

  always_ff @(posedge clk100mhz or negedge reset) begin
    if (!reset) begin
      state  <= ENTRY;
      value  <= '0;
      count  <= '0;
      result <= '0;
    end else begin
      state  <= state_n;
      value  <= value_n;
      count  <= count_n;
      result <= result_n;
    end
  end

  always_comb begin
    state_n  = state;
    value_n  = value;
    count_n  = count;
    result_n = result;
    case (state)
      ENTRY: begin
        if (btn_pulse[1]) begin
          result_n = conv;
          state_n  = SHOW;
        end else if (btn_pulse[0] && count != 3'd4) begin
          value_n = {value[11:0], switches};
          count_n = count + 3'd1;
        end
      end
      SHOW:    ;
      default: state_n = ENTRY;
    endcase
  end

  logic [RW-1:0] refresh_cnt;
  logic [2:0]    scan;

  always_ff @(posedge clk100mhz or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      scan        <= '0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      scan        <= scan + 3'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  logic [3:0] disp_nib;
  logic       disp_blank;
  logic [7:0] seg;

  always_comb begin
    disp_nib   = '0;
    disp_blank = 1'b0;
    if (state == SHOW)  disp_nib = result[{scan, 2'b00} +: 4];
    else if (!scan[2])  disp_nib = value[{scan[1:0], 2'b00} +: 4];
    else                disp_blank = 1'b1;
  end

  always_comb begin
    case (disp_nib)
      4'h0: seg = 8'hC0;  4'h1: seg = 8'hF9;  4'h2: seg = 8'hA4;  4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;  4'h5: seg = 8'h92;  4'h6: seg = 8'h82;  4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;  4'h9: seg = 8'h90;  4'hA: seg = 8'h88;  4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;  4'hD: seg = 8'hA1;  4'hE: seg = 8'h86;  default: seg = 8'h8E;
    endcase
    if (disp_blank) seg = '1;
  end

  always_ff @(posedge clk100mhz or negedge reset) begin
    if (!reset) begin
      anodes   <= '1;
      cathodes <= '1;
    end else begin
      anodes   <= ~(8'b0000_0001 << scan);
      cathodes <= seg;
    end
  end

endmodule

// File: tb/tb_ieee754_top.sv
// Scoreboard bench for ieee754_top: stimulus pushes expected display frames, a monitor captures full scans and compares.
module tb_ieee754_top;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] switches = '0;
  logic       enter = 1'b0;
  logic       confirm = 1'b0;
  logic [7:0] anodes, cathodes;

  ieee754_top #(.REFRESH_DIV(DIV), .DEBOUNCE_CYCLES(3)) dut (
    .clk100mhz(clk), .reset(reset), .switches(switches),
    .enter(enter), .confirm(confirm), .anodes(anodes), .cathodes(cathodes)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic [63:0] q [$];

  // Reference model state
  bit          mshow;
  logic [15:0] mvalue;
  int          mcount;
  logic [31:0] mresult;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_conv(input logic [15:0] v);
    longint s, m, p, mant;
    logic sign;
    s = longint'($signed(v));
    if (s == 0) return 32'h0;
    sign = (s < 0);
    m = sign ? -s : s;
    p = 0;
    while ((longint'(1) << (p + 1)) <= m) p++;
    mant = (m - (longint'(1) << p)) * (longint'(1) << (23 - p));
    return {sign, 8'(127 + p), 23'(mant)};
  endfunction

  function automatic logic [63:0] build_frame(input bit show, input logic [15:0] v, input logic [31:0] r);
    logic [63:0] f;
    for (int i = 0; i < 8; i++) begin
      if (show)       f[8*i +: 8] = font[r[4*i +: 4]];
      else if (i < 4) f[8*i +: 8] = font[v[4*i +: 4]];
      else            f[8*i +: 8] = 8'hFF;
    end
    return f;
  endfunction

  // Monitor: for each expected frame, capture one fresh full scan of the display
  initial begin
    logic [63:0] exp, got;
    logic [7:0]  seen, prev;
    bit          found, onehot_ok;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        exp = q[0];
        got = '1;
        seen = '0;
        onehot_ok = 1'b1;
        found = 1'b0;
        prev = anodes;
        for (int t = 0; t < 200 && !found; t++) begin
          @(negedge clk);
          if (anodes == 8'hFE && prev != 8'hFE) found = 1'b1;
          else prev = anodes;
        end
        if (!found) begin
          check("scan_start_timeout", 32'(anodes), 32'hFE);
        end else begin
          for (int t = 0; t < 8 * DIV; t++) begin
            if ($countones(~anodes) != 1) onehot_ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
              if (!anodes[i]) begin
                got[8*i +: 8] = cathodes;
                seen[i] = 1'b1;
              end
            end
            @(negedge clk);
          end
          check("anode_onehot", 32'(onehot_ok), 32'd1);
          check("digits_seen", 32'(seen), 32'hFF);
          for (int i = 0; i < 8; i++) begin
            check($sformatf("digit%0d", i), 32'(got[8*i +: 8]), 32'(exp[8*i +: 8]));
          end
        end
        void'(q.pop_front());
      end
    end
  end

  task automatic finish_now();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic drain();
    for (int t = 0; t < 3000 && q.size() != 0; t++) @(posedge clk);
    if (q.size() != 0) begin
      check("drain_timeout", 32'(q.size()), 32'd0);
      finish_now();
    end
  endtask

  task automatic expect_model();
    q.push_back(build_frame(mshow, mvalue, mresult));
    drain();
  endtask

  task automatic expect_result(input logic [31:0] r);
    q.push_back(build_frame(1'b1, 16'h0, r));
    drain();
  endtask

  task automatic press(input bit do_enter, input bit do_confirm, input logic [3:0] nib, input int hold);
    switches = nib;
    @(posedge clk); #1;
    enter = do_enter;
    confirm = do_confirm;
    repeat (hold) @(posedge clk);
    #1;
    enter = 1'b0;
    confirm = 1'b0;
    repeat (40) @(posedge clk);
    if (!mshow) begin
      if (do_confirm) begin
        mresult = ref_conv(mvalue);
        mshow = 1'b1;
      end else if (do_enter && mcount < 4) begin
        mvalue = {mvalue[11:0], nib};
        mcount++;
      end
    end
  endtask

  task automatic key(input logic [15:0] v);
    for (int i = 3; i >= 0; i--) press(1'b1, 1'b0, v[4*i +: 4], 6);
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before the next clock edge
  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("rst_anodes", 32'(anodes), 32'hFF);
    check("rst_cathodes", 32'(cathodes), 32'hFF);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    mshow = 1'b0; mvalue = '0; mcount = 0; mresult = '0;
    repeat (5) @(posedge clk);
  endtask

  initial begin
    logic [15:0] rv;
    int n;
    mshow = 1'b0; mvalue = '0; mcount = 0; mresult = '0;
    repeat (4) @(posedge clk);
    #1;
    check("por_anodes", 32'(anodes), 32'hFF);
    check("por_cathodes", 32'(cathodes), 32'hFF);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    expect_model();

    key(16'hFD6C);
    expect_model();
    press(1'b0, 1'b1, 4'h0, 6);
    expect_result(32'hC4250000);
    do_reset();
    expect_model();

    key(16'h0001); press(1'b0, 1'b1, 4'h0, 6); expect_result(32'h3F800000); do_reset();
    key(16'h8000); press(1'b0, 1'b1, 4'h0, 6); expect_result(32'hC7000000); do_reset();
    key(16'h7FFF); press(1'b0, 1'b1, 4'h0, 6); expect_result(32'h46FFFE00); do_reset();

    press(1'b0, 1'b1, 4'h0, 6);
    expect_result(32'h00000000);
    do_reset();

    key(16'h1234);
    press(1'b1, 1'b0, 4'h5, 6);
    expect_model();
    press(1'b0, 1'b1, 4'h0, 6);
    press(1'b1, 1'b0, 4'h9, 6);
    press(1'b0, 1'b1, 4'h0, 6);
    expect_model();
    do_reset();

    // Mid-entry reset must discard the partial value
    press(1'b1, 1'b0, 4'h7, 6);
    do_reset();
    expect_model();

    press(1'b1, 1'b0, 4'hA, 100);
    expect_model();
    do_reset();

    press(1'b1, 1'b0, 4'h3, 6);
    press(1'b1, 1'b0, 4'h4, 6);
    press(1'b1, 1'b1, 4'h5, 6);
    expect_model();
    do_reset();

    for (int it = 0; it < 8; it++) begin
      rv = 16'($urandom);
      n = int'($urandom_range(4, 0));
      for (int i = 0; i < n; i++) press(1'b1, 1'b0, rv[4*i +: 4], int'($urandom_range(12, 4)));
      expect_model();
      press(1'b0, 1'b1, 4'h0, 6);
      expect_model();
      do_reset();
    end

    finish_now();
  end

endmodule
